wb_stage_pipe: RTL and testbench

- Registered, parametrised write-back stage for the ARM pipeline.
- Takes one retiring instruction per cycle from the MEM stage and selects its result from ALU, load data, or link value.
- Drives the register-file write port one cycle later.
- Unlike the combinational WB mux, it tolerates multi-cycle load returns (stalls MEM via in_ready), supports flush, counts retired instructions, and flags load timeouts.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_src_mux.sv | 24 ++
 rtl/wb_stage_pipe.sv | 163 ++++++++++++++++
 tb/tb_wb_stage_pipe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared source-select codes and FSM encoding for the registered write-back stage.
package wb_pkg;

   localparam logic [1:0] SRC_ALU  = 2'd0;
   localparam logic [1:0] SRC_MEM  = 2'd1;
   localparam logic [1:0] SRC_LINK = 2'd2;

   typedef enum logic {
      WB_IDLE     = 1'b0,
      WB_WAIT_MEM = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_src_mux.sv
// Result-source select for write-back (ALU / load / link; reserved code reads as ALU).
// Purely combinational, zero latency, no flow control.
module wb_src_mux
   import wb_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]        src_sel,
   input  logic [DATA_W-1:0] alu_value,
   input  logic [DATA_W-1:0] mem_value,
   input  logic [DATA_W-1:0] link_value,
   output logic [DATA_W-1:0] result
);

   always_comb begin
      result = alu_value;
      case (src_sel)
         SRC_MEM:  result = mem_value;
         SRC_LINK: result = link_value;
         default:  result = alu_value;
      endcase
   end

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered write-back stage: one retire per cycle, write port valid 1 cycle after accept.
// Deasserts in_ready while a late load is outstanding; drops the load on timeout or flush.
module wb_stage_pipe
   import wb_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int REG_ADDR_W  = 4,
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_wb_en,
   input  logic [REG_ADDR_W-1:0] in_dest,
   input  logic [1:0]            in_src_sel,
   input  logic [DATA_W-1:0]     in_alu_result,
   input  logic [DATA_W-1:0]     in_link_value,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  mem_rdata_valid,
   output logic                  wb_en,
   output logic [REG_ADDR_W-1:0] wb_dest,
   output logic [DATA_W-1:0]     wb_value,
   output logic                  pend_valid,
   output logic [REG_ADDR_W-1:0] pend_dest,
   output logic [CNT_W-1:0]      retire_count,
   output logic                  load_err
);

   localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

   wb_state_e             state_q, state_d;
   logic                  wb_en_q, wb_en_d;
   logic [REG_ADDR_W-1:0] wb_dest_q, wb_dest_d;
   logic [DATA_W-1:0]     wb_value_q, wb_value_d;
   logic                  pend_valid_q, pend_valid_d;
   logic                  pend_en_q, pend_en_d;
   logic [REG_ADDR_W-1:0] pend_dest_q, pend_dest_d;
   logic [TO_W-1:0]       wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]      retire_count_q, retire_count_d;
   logic                  load_err_q, load_err_d;

   logic                  accept, is_load, retire_now, defer;
   logic                  wait_live, retire_late, timeout;
   logic [DATA_W-1:0]     mux_result;

   wb_src_mux #(
      .DATA_W (DATA_W)
   ) u_src_mux (
      .src_sel    (in_src_sel),
      .alu_value  (in_alu_result),
      .mem_value  (mem_rdata),
      .link_value (in_link_value),
      .result     (mux_result)
   );

   assign in_ready    = (state_q == WB_IDLE);
   assign accept      = in_valid & in_ready & ~flush;
   assign is_load     = (in_src_sel == SRC_MEM);
   assign retire_now  = accept & (~is_load | mem_rdata_valid);
   assign defer       = accept & is_load & ~mem_rdata_valid;
   // flush masks both data arrival and timeout while a load is pending
   assign wait_live   = (state_q == WB_WAIT_MEM) & ~flush;
   assign retire_late = wait_live & mem_rdata_valid;
   assign timeout     = wait_live & ~mem_rdata_valid & (wait_cnt_q == TO_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= WB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         WB_IDLE:     if (defer) state_d = WB_WAIT_MEM;
         WB_WAIT_MEM: if (flush | mem_rdata_valid | timeout) state_d = WB_IDLE;
         default:     state_d = WB_IDLE;
      endcase
   end

   always_comb begin
      wb_en_d        = 1'b0;
      wb_dest_d      = wb_dest_q;
      wb_value_d     = wb_value_q;
      pend_valid_d   = pend_valid_q;
      pend_en_d      = pend_en_q;
      pend_dest_d    = pend_dest_q;
      wait_cnt_d     = wait_cnt_q;
      retire_count_d = retire_count_q;
      load_err_d     = 1'b0;

      if (retire_now) begin
         wb_en_d    = in_wb_en;
         wb_dest_d  = in_dest;
         wb_value_d = mux_result;
      end
      if (defer) begin
         pend_valid_d = 1'b1;
         pend_en_d    = in_wb_en;
         pend_dest_d  = in_dest;
         wait_cnt_d   = '0;
      end
      if (retire_late) begin
         wb_en_d      = pend_en_q;
         wb_dest_d    = pend_dest_q;
         wb_value_d   = mem_rdata;
         pend_valid_d = 1'b0;
      end
      if ((state_q == WB_WAIT_MEM) && flush) begin
         pend_valid_d = 1'b0;
      end
      if (wait_live && !mem_rdata_valid) begin
         if (timeout) begin
            pend_valid_d = 1'b0;
            load_err_d   = 1'b1;
         end else begin
            wait_cnt_d = wait_cnt_q + TO_W'(1);
         end
      end
      if (retire_now || retire_late) begin
         retire_count_d = retire_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_en_q        <= 1'b0;
         wb_dest_q      <= '0;
         wb_value_q     <= '0;
         pend_valid_q   <= 1'b0;
         pend_en_q      <= 1'b0;
         pend_dest_q    <= '0;
         wait_cnt_q     <= '0;
         retire_count_q <= '0;
         load_err_q     <= 1'b0;
      end else begin
         wb_en_q        <= wb_en_d;
         wb_dest_q      <= wb_dest_d;
         wb_value_q     <= wb_value_d;
         pend_valid_q   <= pend_valid_d;
         pend_en_q      <= pend_en_d;
         pend_dest_q    <= pend_dest_d;
         wait_cnt_q     <= wait_cnt_d;
         retire_count_q <= retire_count_d;
         load_err_q     <= load_err_d;
      end
   end

   assign wb_en        = wb_en_q;
   assign wb_dest      = wb_dest_q;
   assign wb_value     = wb_value_q;
   assign pend_valid   = pend_valid_q;
   assign pend_dest    = pend_dest_q;
   assign retire_count = retire_count_q;
   assign load_err     = load_err_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe with a short load timeout.
module tb_wb_stage_pipe;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int CW = 32;
   localparam int TO = 8;

   logic          clk;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic          in_wb_en;
   logic [AW-1:0] in_dest;
   logic [1:0]    in_src_sel;
   logic [DW-1:0] in_alu_result;
   logic [DW-1:0] in_link_value;
   logic [DW-1:0] mem_rdata;
   logic          mem_rdata_valid;
   logic          wb_en;
   logic [AW-1:0] wb_dest;
   logic [DW-1:0] wb_value;
   logic          pend_valid;
   logic [AW-1:0] pend_dest;
   logic [CW-1:0] retire_count;
   logic          load_err;

   int n_checks = 0;
   int n_errors = 0;

   wb_stage_pipe #(
      .DATA_W      (DW),
      .REG_ADDR_W  (AW),
      .CNT_W       (CW),
      .MEM_TIMEOUT (TO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_wb_en        (in_wb_en),
      .in_dest         (in_dest),
      .in_src_sel      (in_src_sel),
      .in_alu_result   (in_alu_result),
      .in_link_value   (in_link_value),
      .mem_rdata       (mem_rdata),
      .mem_rdata_valid (mem_rdata_valid),
      .wb_en           (wb_en),
      .wb_dest         (wb_dest),
      .wb_value        (wb_value),
      .pend_valid      (pend_valid),
      .pend_dest       (pend_dest),
      .retire_count    (retire_count),
      .load_err        (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush = 1'b0; in_valid = 1'b0; in_wb_en = 1'b0; in_dest = '0; in_src_sel = 2'd0;
      in_alu_result = '0; in_link_value = '0; mem_rdata = '0; mem_rdata_valid = 1'b0;
   endtask

   task automatic issue(input logic [1:0] sel, input logic en, input logic [AW-1:0] dest,
                        input logic [DW-1:0] alu, input logic [DW-1:0] link,
                        input logic [DW-1:0] rdata, input logic rvld);
      in_valid = 1'b1; in_src_sel = sel; in_wb_en = en; in_dest = dest;
      in_alu_result = alu; in_link_value = link; mem_rdata = rdata; mem_rdata_valid = rvld;
   endtask

   task automatic check_write(input string tag, input logic en, input logic [AW-1:0] dest,
                              input logic [DW-1:0] val, input logic [CW-1:0] cnt);
      check_eq({tag, ".wb_en"}, 64'(wb_en), 64'(en));
      check_eq({tag, ".wb_dest"}, 64'(wb_dest), 64'(dest));
      check_eq({tag, ".wb_value"}, 64'(wb_value), 64'(val));
      check_eq({tag, ".retire_count"}, 64'(retire_count), 64'(cnt));
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, ".wb_en"}, 64'(wb_en), 64'(0));
      check_eq({tag, ".wb_dest"}, 64'(wb_dest), 64'(0));
      check_eq({tag, ".wb_value"}, 64'(wb_value), 64'(0));
      check_eq({tag, ".pend_valid"}, 64'(pend_valid), 64'(0));
      check_eq({tag, ".pend_dest"}, 64'(pend_dest), 64'(0));
      check_eq({tag, ".retire_count"}, 64'(retire_count), 64'(0));
      check_eq({tag, ".load_err"}, 64'(load_err), 64'(0));
      check_eq({tag, ".in_ready"}, 64'(in_ready), 64'(1));
   endtask

   initial begin
      int k;
      int wb_pulses;

      rst = 1'b0;
      idle_inputs();
      #12;
      check_zero_outputs("reset");
      rst = 1'b1;

      // single ALU retire
      issue(2'd0, 1'b1, 4'd3, 32'h0000_00A5, 32'h0, 32'h0, 1'b0);
      step();
      check_write("alu", 1'b1, 4'd3, 32'h0000_00A5, 32'd1);
      idle_inputs();
      step();
      check_write("alu_hold", 1'b0, 4'd3, 32'h0000_00A5, 32'd1);

      // back-to-back ALU, LINK, same-cycle load
      issue(2'd0, 1'b1, 4'd7, 32'h0000_0077, 32'hFFFF_0000, 32'h0, 1'b0);
      step();
      check_write("b2b_alu", 1'b1, 4'd7, 32'h0000_0077, 32'd2);
      check_eq("b2b_alu.in_ready", 64'(in_ready), 64'(1));
      issue(2'd2, 1'b1, 4'd14, 32'h5555_5555, 32'h0000_1004, 32'h0, 1'b0);
      step();
      check_write("b2b_link", 1'b1, 4'd14, 32'h0000_1004, 32'd3);
      check_eq("b2b_link.in_ready", 64'(in_ready), 64'(1));
      issue(2'd1, 1'b1, 4'd2, 32'h5555_5555, 32'h0, 32'hDEAD_BEEF, 1'b1);
      step();
      check_write("b2b_load", 1'b1, 4'd2, 32'hDEAD_BEEF, 32'd4);
      check_eq("b2b_load.in_ready", 64'(in_ready), 64'(1));

      // reserved select reads ALU; no-write instruction still retires
      issue(2'd3, 1'b0, 4'd9, 32'h0000_0033, 32'h0000_0044, 32'h0000_0055, 1'b0);
      step();
      check_write("rsvd_nowrite", 1'b0, 4'd9, 32'h0000_0033, 32'd5);

      // late load: data four cycles after accept
      issue(2'd1, 1'b1, 4'd5, 32'h0, 32'h0, 32'h0000_0BAD, 1'b0);
      step();
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         check_eq("late.in_ready", 64'(in_ready), 64'(0));
         check_eq("late.pend_valid", 64'(pend_valid), 64'(1));
         check_eq("late.pend_dest", 64'(pend_dest), 64'(5));
         check_eq("late.wb_en", 64'(wb_en), 64'(0));
         if (i == 3) begin
            mem_rdata = 32'h1234_5678;
            mem_rdata_valid = 1'b1;
         end
         step();
      end
      idle_inputs();
      check_write("late_wr", 1'b1, 4'd5, 32'h1234_5678, 32'd6);
      check_eq("late_wr.in_ready", 64'(in_ready), 64'(1));
      check_eq("late_wr.pend_valid", 64'(pend_valid), 64'(0));

      // stray load data while idle is ignored
      mem_rdata = 32'hCAFE_F00D;
      mem_rdata_valid = 1'b1;
      step();
      idle_inputs();
      check_write("stray_data", 1'b0, 4'd5, 32'h1234_5678, 32'd6);

      // timeout: load_err eight cycles after entering the wait
      issue(2'd1, 1'b1, 4'd6, 32'h0, 32'h0, 32'h0, 1'b0);
      step();
      idle_inputs();
      k = 0;
      wb_pulses = 0;
      while (k < 20 && load_err !== 1'b1) begin
         step();
         k++;
         if (wb_en === 1'b1) wb_pulses++;
      end
      check_eq("timeout.latency", 64'(k), 64'(8));
      check_eq("timeout.no_write", 64'(wb_pulses), 64'(0));
      check_eq("timeout.retire_count", 64'(retire_count), 64'(6));
      check_eq("timeout.pend_valid", 64'(pend_valid), 64'(0));
      check_eq("timeout.in_ready", 64'(in_ready), 64'(1));
      step();
      check_eq("timeout.pulse_once", 64'(load_err), 64'(0));
      issue(2'd0, 1'b1, 4'd1, 32'h0000_C0DE, 32'h0, 32'h0, 1'b0);
      step();
      idle_inputs();
      check_write("after_timeout", 1'b1, 4'd1, 32'h0000_C0DE, 32'd7);

      // flush beats simultaneous load data
      issue(2'd1, 1'b1, 4'd8, 32'h0, 32'h0, 32'h0, 1'b0);
      step();
      idle_inputs();
      step();
      flush = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      mem_rdata_valid = 1'b1;
      step();
      idle_inputs();
      check_write("flush_data", 1'b0, 4'd1, 32'h0000_C0DE, 32'd7);
      check_eq("flush_data.load_err", 64'(load_err), 64'(0));
      check_eq("flush_data.pend_valid", 64'(pend_valid), 64'(0));
      check_eq("flush_data.in_ready", 64'(in_ready), 64'(1));

      // flush while idle discards the input
      issue(2'd0, 1'b1, 4'd10, 32'h0000_00AA, 32'h0, 32'h0, 1'b0);
      flush = 1'b1;
      step();
      idle_inputs();
      check_write("flush_idle", 1'b0, 4'd1, 32'h0000_C0DE, 32'd7);

      // asynchronous reset while a load is pending
      issue(2'd1, 1'b1, 4'd11, 32'h0, 32'h0, 32'h0, 1'b0);
      step();
      idle_inputs();
      check_eq("pre_rst.pend_valid", 64'(pend_valid), 64'(1));
      #2;
      rst = 1'b0;
      #1;
      check_zero_outputs("async_rst");
      #3;
      rst = 1'b1;
      step();
      issue(2'd0, 1'b1, 4'd4, 32'h0000_0042, 32'h0, 32'h0, 1'b0);
      step();
      idle_inputs();
      check_write("post_rst", 1'b1, 4'd4, 32'h0000_0042, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1);
   end

endmodule
